// File: rtl/debug_cmd_parser.sv
// debug_cmd_parser: decodes a UART byte stream of debug commands and turns them
// into 32-bit bus reads and writes, read-data replies, a liveness reply and a
// core reset control.
// Optional feature macro: DBG_CMD_TIMEOUT_EN. When it is defined, a payload
// that stalls for TIMEOUT_CYCLES clocks is abandoned.
module debug_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wen,
    output logic        bus_ren,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam logic [7:0] OP_SET_COUNT = 8'h82;
    localparam logic [7:0] OP_SET_ADDR  = 8'h83;
    localparam logic [7:0] OP_READ      = 8'h84;
    localparam logic [7:0] OP_WRITE     = 8'h85;
    localparam logic [7:0] OP_ALIVE     = 8'h86;
    localparam logic [7:0] OP_CORE_RST  = 8'h87;
    localparam logic [7:0] OP_CORE_RUN  = 8'h88;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_BUS_WR,
        S_BUS_RD,
        S_TX_WORD,
        S_TX_ALIVE
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [7:0]  count_q,    count_d;
    logic [7:0]  opcode_q,   opcode_d;
    logic [23:0] shift_q,    shift_d;    // payload bytes received so far
    logic [1:0]  pidx_q,     pidx_d;     // index of the next payload byte
    logic [1:0]  txidx_q,    txidx_d;    // index of the byte being offered
    logic        core_rst_q, core_rst_d;
    logic        overrun_q,  overrun_d;
    logic [1:0]  plast;                  // index of the final payload byte
    logic        timeout_hit;

    assign plast = (opcode_q == OP_SET_COUNT) ? 2'd0 : 2'd3;

`ifdef DBG_CMD_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Count idle cycles inside a payload; any received byte restarts the count.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        timeout_hit = 1'b0;
        if (rx_valid || (state_q != S_PAYLOAD)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TIMEOUT_CYCLES - 1) begin
            timeout_hit = 1'b1;
            idle_cnt_d  = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
    end

    // Idle counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        count_d    = count_q;
        opcode_d   = opcode_q;
        shift_d    = shift_q;
        pidx_d     = pidx_q;
        txidx_d    = txidx_q;
        core_rst_d = core_rst_q;
        // A byte arriving while a bus or transmit operation runs is lost.
        overrun_d  = rx_valid && (state_q != S_IDLE) && (state_q != S_PAYLOAD);

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data[7]) begin
                    case (rx_data)
                        OP_SET_COUNT, OP_SET_ADDR, OP_WRITE: begin
                            opcode_d = rx_data;
                            pidx_d   = 2'd0;
                            state_d  = S_PAYLOAD;
                        end
                        OP_READ: begin
                            if (count_q != 8'd0) begin
                                state_d = S_BUS_RD;
                            end
                        end
                        OP_ALIVE: begin
                            txidx_d = 2'd0;
                            state_d = S_TX_ALIVE;
                        end
                        OP_CORE_RST: core_rst_d = 1'b1;
                        OP_CORE_RUN: core_rst_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    shift_d = {shift_q[15:0], rx_data};
                    if (pidx_q == plast) begin
                        pidx_d  = 2'd0;
                        state_d = S_IDLE;
                        case (opcode_q)
                            OP_SET_COUNT: count_d = rx_data;
                            OP_SET_ADDR:  addr_d  = {shift_q, rx_data};
                            OP_WRITE: begin
                                wdata_d = {shift_q, rx_data};
                                state_d = S_BUS_WR;
                            end
                            default: ;
                        endcase
                    end else begin
                        pidx_d = pidx_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    pidx_d  = 2'd0;
                    state_d = S_IDLE;
                end
            end
            S_BUS_WR: begin
                if (bus_ack) begin
                    addr_d  = addr_q + 32'd4;
                    state_d = S_IDLE;
                end
            end
            S_BUS_RD: begin
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q - 8'd1;
                    txidx_d = 2'd0;
                    state_d = S_TX_WORD;
                end
            end
            S_TX_WORD: begin
                if (tx_ready) begin
                    if (txidx_q == 2'd3) begin
                        txidx_d = 2'd0;
                        state_d = (count_q != 8'd0) ? S_BUS_RD : S_IDLE;
                    end else begin
                        txidx_d = txidx_q + 2'd1;
                    end
                end
            end
            S_TX_ALIVE: begin
                if (tx_ready) begin
                    if (txidx_q == 2'd1) begin
                        txidx_d = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        txidx_d = 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            count_q    <= '0;
            opcode_q   <= '0;
            shift_q    <= '0;
            pidx_q     <= '0;
            txidx_q    <= '0;
            core_rst_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            count_q    <= count_d;
            opcode_q   <= opcode_d;
            shift_q    <= shift_d;
            pidx_q     <= pidx_d;
            txidx_q    <= txidx_d;
            core_rst_q <= core_rst_d;
            overrun_q  <= overrun_d;
        end
    end

    // Select the outgoing byte: read word MSB first, or the 0x00/0xAE reply.
    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_TX_WORD) begin
            case (txidx_q)
                2'd0:    tx_data = rdata_q[31:24];
                2'd1:    tx_data = rdata_q[23:16];
                2'd2:    tx_data = rdata_q[15:8];
                default: tx_data = rdata_q[7:0];
            endcase
        end else if (state_q == S_TX_ALIVE) begin
            tx_data = (txidx_q == 2'd0) ? 8'h00 : 8'hAE;
        end
    end

    assign tx_valid   = (state_q == S_TX_WORD) || (state_q == S_TX_ALIVE);
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_wen    = (state_q == S_BUS_WR);
    assign bus_ren    = (state_q == S_BUS_RD);
    assign core_rst_o = core_rst_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Bench for debug_cmd_parser: directed scenarios followed by random command
// traffic, all checked against a command-level reference model.
module tb_debug_cmd_parser;

    localparam int unsigned TB_TIMEOUT = 40;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic        bus_ren;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        core_rst_o;
    logic        busy_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;

    // Reference model: the parser's architectural state at command level.
    logic [31:0] m_addr;
    logic [7:0]  m_count;
    logic        m_core_rst;

    always #5 wb_clk_i = ~wb_clk_i;

    debug_cmd_parser #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wen    (bus_wen),
        .bus_ren    (bus_ren),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .core_rst_o (core_rst_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge wb_clk_i);
    endtask

    // Present one byte for a single clock; returns at the following negedge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_wen"}, bus_wen, 0);
        chk({tag, "_ren"}, bus_ren, 0);
        chk({tag, "_txv"}, tx_valid, 0);
        chk({tag, "_addr"}, bus_addr, m_addr);
        chk({tag, "_crst"}, core_rst_o, m_core_rst);
    endtask

    // Opcode followed by n payload bytes MSB first, with random idle gaps.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] val, input int n);
        int gap;
        send(op);
        for (int i = n - 1; i >= 0; i--) begin
            gap = $urandom_range(0, 3);
            repeat (gap) cyc();
            send(val[8*i +: 8]);
        end
    endtask

    task automatic do_set_count(input logic [7:0] c);
        send_cmd(8'h82, {24'h0, c}, 1);
        m_count = c;
        idle_check("setcnt");
    endtask

    task automatic do_set_addr(input logic [31:0] a);
        send_cmd(8'h83, a, 4);
        m_addr = a;
        idle_check("setaddr");
    endtask

    task automatic do_write(input logic [31:0] d);
        int stall;
        send_cmd(8'h85, d, 4);
        chk("wr_wen", bus_wen, 1);
        chk("wr_ren", bus_ren, 0);
        chk("wr_addr", bus_addr, m_addr);
        chk("wr_data", bus_wdata, d);
        stall = $urandom_range(0, 3);
        repeat (stall) begin
            cyc();
            chk("wr_hold_wen", bus_wen, 1);
            chk("wr_hold_addr", bus_addr, m_addr);
            chk("wr_hold_data", bus_wdata, d);
        end
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        m_addr = m_addr + 32'd4;
        chk("wr_done_wen", bus_wen, 0);
        chk("wr_done_busy", busy_o, 0);
        chk("wr_done_addr", bus_addr, m_addr);
    endtask

    // inject: 0 none, 1 byte while waiting for the first ack, 2 byte together with it.
    task automatic do_read(input bit fixed, input int inject);
        int          widx;
        int          stall;
        logic [31:0] word;
        logic [7:0]  expb;
        send(8'h84);
        if (m_count == 8'd0) begin
            chk("rd0_busy", busy_o, 0);
            chk("rd0_ren", bus_ren, 0);
        end
        widx = 0;
        while (m_count != 8'd0) begin
            chk("rd_ren", bus_ren, 1);
            chk("rd_wen", bus_wen, 0);
            chk("rd_addr", bus_addr, m_addr);
            chk("rd_txv", tx_valid, 0);
            stall = $urandom_range(0, 2);
            repeat (stall) cyc();
            if (widx == 0 && inject == 1) begin
                rx_data  = 8'h83;
                rx_valid = 1'b1;
                cyc();
                rx_valid = 1'b0;
                chk("ovr_pulse", overrun_o, 1);
                chk("ovr_ren", bus_ren, 1);
                chk("ovr_addr", bus_addr, m_addr);
                cyc();
                chk("ovr_clear", overrun_o, 0);
                chk("ovr_ren2", bus_ren, 1);
            end
            word = fixed ? (32'h11223344 + widx * 32'h44444444) : $urandom;
            bus_rdata = word;
            bus_ack   = 1'b1;
            if (widx == 0 && inject == 2) begin
                rx_data  = 8'hC3;
                rx_valid = 1'b1;
            end
            cyc();
            bus_ack   = 1'b0;
            rx_valid  = 1'b0;
            bus_rdata = $urandom;
            if (widx == 0 && inject == 2) begin
                chk("ovr_ack_pulse", overrun_o, 1);
                chk("ovr_ack_txv", tx_valid, 1);
            end
            m_addr  = m_addr + 32'd4;
            m_count = m_count - 8'd1;
            for (int k = 0; k < 4; k++) begin
                expb  = word[31-8*k -: 8];
                stall = $urandom_range(0, 2);
                repeat (stall) begin
                    chk("tx_stall_v", tx_valid, 1);
                    chk("tx_stall_d", tx_data, expb);
                    cyc();
                end
                chk("tx_v", tx_valid, 1);
                chk("tx_byte", tx_data, expb);
                chk("tx_ovr", overrun_o, 0);
                chk("tx_ren", bus_ren, 0);
                tx_ready = 1'b1;
                cyc();
                tx_ready = 1'b0;
            end
            widx++;
        end
        idle_check("rd_end");
    endtask

    task automatic do_alive(input int stall0);
        send(8'h86);
        chk("alive_v0", tx_valid, 1);
        chk("alive_b0", tx_data, 8'h00);
        repeat (stall0) begin
            cyc();
            chk("alive_hold_v", tx_valid, 1);
            chk("alive_hold_b", tx_data, 8'h00);
            chk("alive_hold_ovr", overrun_o, 0);
        end
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("alive_v1", tx_valid, 1);
        chk("alive_b1", tx_data, 8'hAE);
        chk("alive_ovr", overrun_o, 0);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        idle_check("alive_end");
    endtask

    task automatic do_core(input logic [7:0] op);
        chk("core_pre", core_rst_o, m_core_rst);
        send(op);
        m_core_rst = (op == 8'h87);
        chk("core_post", core_rst_o, m_core_rst);
        chk("core_busy", busy_o, 0);
    endtask

    task automatic do_junk(input logic [7:0] b);
        send(b);
        idle_check("junk");
    endtask

    initial begin
        logic [7:0] jb;
        int         op;

        wb_rst_i  = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        m_addr    = 32'h0;
        m_count   = 8'h0;
        m_core_rst = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", busy_o, 0);
        chk("rst_wen", bus_wen, 0);
        chk("rst_ren", bus_ren, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_crst", core_rst_o, 0);
        chk("rst_ovr", overrun_o, 0);
        wb_rst_i = 1'b0;
        cyc();

        // Address then write.
        do_set_addr(32'h0000_8000);
        do_write(32'hDEAD_BEEF);
        chk("wr_addr_const", bus_addr, 32'h0000_8004);

        // Two-word read burst with known data.
        do_set_count(8'd2);
        do_set_addr(32'h0000_8000);
        do_read(1'b1, 0);
        chk("rd_burst_addr", bus_addr, 32'h0000_8008);

        // Read with zero count is ignored.
        do_read(1'b0, 0);

        // Liveness reply with a long transmit stall.
        do_alive(10);

        // Core reset control and ignored bytes.
        do_core(8'h87);
        do_junk(8'h45);
        do_junk(8'h9F);
        do_core(8'h88);

        // Overrun while waiting for the bus, and together with the ack.
        do_set_count(8'd1);
        do_read(1'b0, 1);
        do_set_count(8'd2);
        do_read(1'b0, 2);

        // Address wrap on write.
        do_set_addr(32'hFFFF_FFFC);
        do_write(32'h1234_5678);
        chk("wrap_addr", bus_addr, 32'h0);

        // Reset asserted in the middle of a read reply.
        do_core(8'h87);
        do_set_count(8'd1);
        send(8'h84);
        bus_rdata = 32'hA5A5_5A5A;
        bus_ack   = 1'b1;
        cyc();
        bus_ack   = 1'b0;
        chk("mid_txv", tx_valid, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_txv", tx_valid, 0);
        chk("mrst_txd", tx_data, 0);
        chk("mrst_wen", bus_wen, 0);
        chk("mrst_ren", bus_ren, 0);
        chk("mrst_addr", bus_addr, 0);
        chk("mrst_wdata", bus_wdata, 0);
        chk("mrst_crst", core_rst_o, 0);
        chk("mrst_ovr", overrun_o, 0);
        cyc();
        wb_rst_i = 1'b0;
        m_addr     = 32'h0;
        m_count    = 8'h0;
        m_core_rst = 1'b0;
        do_alive(0);
        do_read(1'b0, 0);

        // Stalled payload: abandoned when the timeout is built in, kept otherwise.
        do_set_addr(32'h0000_0100);
        send(8'h83);
        send(8'h12);
        send(8'h34);
`ifdef DBG_CMD_TIMEOUT_EN
        repeat (TB_TIMEOUT - 1) cyc();
        chk("to_before", busy_o, 1);
        cyc();
        chk("to_after", busy_o, 0);
        chk("to_addr", bus_addr, m_addr);
        do_alive(0);
`else
        repeat (TB_TIMEOUT + 10) cyc();
        chk("nto_busy", busy_o, 1);
        send(8'h56);
        send(8'h78);
        m_addr = 32'h1234_5678;
        idle_check("nto_done");
`endif

        // Random command traffic against the model.
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: do_set_count(8'($urandom_range(0, 3)));
                1: begin
                    if ($urandom_range(0, 3) == 0)
                        do_set_addr(32'hFFFF_FFF8 + 32'($urandom_range(0, 7)));
                    else
                        do_set_addr($urandom);
                end
                2: do_write($urandom);
                3: do_read(1'b0, $urandom_range(0, 2));
                4: do_alive($urandom_range(0, 3));
                5: do_core(8'h87);
                6: do_core(8'h88);
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        jb = 8'($urandom_range(0, 127));
                    else
                        jb = 8'($urandom_range(137, 255));
                    do_junk(jb);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_cmd_parser.md
DEBUG_CMD_PARSER -- requirements
Module: debug_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: inter-byte idle limit in clock cycles; used only when the timeout feature is compiled in.
REQ-002 Ports: one clock; reset is asynchronous and active-high.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
REQ-003 UART receive side:
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle strobe, byte valid.
REQ-004 UART transmit side:
- tx_data  out  8  byte to send.
- tx_valid  out  1  byte offered.
- tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-005 Bus master side:
- bus_addr  out  32  word address.
- bus_wdata  out  32  write data.
- bus_wen  out  1  write request.
- bus_ren  out  1  read request.
- bus_ack  in  1  single-cycle completion.
- bus_rdata  in  32  read data, valid with bus_ack.
REQ-006 Status and control outputs:
- core_rst_o  out  1  core held in reset.
- busy_o  out  1  state not IDLE.
- overrun_o  out  1  single-cycle pulse, byte dropped.

Function
REQ-007 States: IDLE, PAYLOAD, BUS_WR, BUS_RD, TX_WORD, TX_ALIVE.
REQ-008 In IDLE, the opcode is the byte with bit7=1; bytes with bit7=0 and unknown opcodes are discarded silently.
REQ-009 Opcode 0x82 (SET_COUNT): collect 1 payload byte into count[7:0].
REQ-010 Opcode 0x83 (SET_ADDR): collect 4 payload bytes MSB first into addr[31:0].
REQ-011 Opcode 0x85 (WRITE_DATA): collect 4 payload bytes MSB first into wdata, then enter BUS_WR.
REQ-012 Payload bytes are raw data; bit7 is not interpreted in PAYLOAD.
REQ-013 Opcode 0x84 (READ_DATA): if count=0, stay in IDLE; otherwise enter BUS_RD.
REQ-014 Opcode 0x86 (ALIVE): enter TX_ALIVE and send 0x00 then 0xAE.
REQ-015 Opcode 0x87 sets core_rst_o=1 the cycle after the strobe; opcode 0x88 clears it. Both stay in IDLE.
REQ-016 BUS_WR: bus_wen=1, bus_addr=addr, bus_wdata=wdata, all held stable until bus_ack.
- Cycle after bus_ack: bus_wen=0, addr+=4 (wraps modulo 2^32), return to IDLE.
REQ-017 BUS_RD: bus_ren=1 with bus_addr=addr, held until bus_ack.
- On bus_ack: latch bus_rdata, addr+=4, count-=1, enter TX_WORD.
REQ-018 TX_WORD: offer the latched word as 4 bytes MSB first, each byte held until tx_ready.
- After the 4th byte: count≠0 returns to BUS_RD, count=0 returns to IDLE.
REQ-019 tx_valid is low outside TX_WORD and TX_ALIVE.
REQ-020 Latency: bus request asserts the cycle after the final payload byte's rx_valid, or the cycle after the READ opcode strobe.
REQ-021 Any rx_valid while in BUS_WR, BUS_RD, TX_WORD or TX_ALIVE: byte dropped, overrun_o pulses 1 cycle, state unchanged.
REQ-022 rx_valid and bus_ack in the same cycle: bus_ack is processed, the byte is dropped, overrun_o pulses.
REQ-023 bus_wen and bus_ren are never high simultaneously.
REQ-024 busy_o = (state≠IDLE).

Reset
REQ-025 wb_rst_i forces immediately, mid-operation included:
- state=IDLE.
- addr=0, count=0, wdata=0, latched read word=0, payload index=0.
- bus_wen=0, bus_ren=0, tx_valid=0, tx_data=0.
- core_rst_o=0, overrun_o=0.
REQ-026 After wb_rst_i deasserts, the first valid opcode is accepted on the next rx_valid.

Configuration
REQ-027 Macro DBG_CMD_TIMEOUT_EN defined: in PAYLOAD, a counter cleared on each rx_valid aborts to IDLE after TIMEOUT_CYCLES cycles with no byte; partial payload is discarded and addr/count/wdata are unchanged.
REQ-028 Macro DBG_CMD_TIMEOUT_EN undefined: no counter; PAYLOAD waits indefinitely.

Verification
REQ-029 Send 0x83,00,00,80,00; then 0x85,DE,AD,BE,EF -> one bus write of addr 0x00008000, data 0xDEADBEEF; addr afterwards 0x00008004.
REQ-030 Send 0x82,02; 0x83,00,00,80,00; 0x84 with bus returning 0x11223344 then 0x55667788 -> reads at 0x8000 and 0x8004; tx bytes 11,22,33,44,55,66,77,88.
REQ-031 Send 0x86 with tx_ready held low for 10 cycles -> tx_data=0x00 stable until accepted, then 0xAE; overrun_o never pulses.
REQ-032 Send 0x87 then 0x88 -> core_rst_o rises the cycle after the 1st strobe, falls the cycle after the 2nd; 0x45 and 0x9F cause no effect.
REQ-033 Hold bus_ack low during BUS_RD, send byte 0x83 -> overrun_o pulses once; state and addr unchanged. Assert wb_rst_i mid-TX_WORD -> all outputs return to reset values that cycle.
REQ-034 With DBG_CMD_TIMEOUT_EN: send 0x83,12,34 then idle for TIMEOUT_CYCLES -> return to IDLE; addr unchanged; next 0x86 answers 0x00,0xAE.
